seven_seg_scan_driver: RTL and testbench

//  Consumes the 32-bit out_port word from the seven-segment PIO output register and drives a

---
 rtl/seven_seg_scan_driver.sv | 91 +++++++++
 tb/tb_seven_seg_scan_driver.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_driver.sv
// Multiplexed common-anode 7-segment scan driver with per-digit ghost blanking and frame-coherent snapshot.
// Optional macro SEVEN_SEG_LZ_SUPPRESS_EN blanks leading-zero digits (digit 0 always shown).
module seven_seg_scan_driver #(
  parameter int NUM_DIGITS   = 8,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [31:0]           value,
  input  logic [NUM_DIGITS-1:0] dp_mask,
  output logic [6:0]            seg_n,
  output logic                  dp_n,
  output logic [NUM_DIGITS-1:0] an_n
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int VW = 4 * NUM_DIGITS;
  localparam logic [PW-1:0] PRE_LAST  = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] BLANK_END = PW'(BLANK_CYCLES);
  localparam logic [DW-1:0] DIG_LAST  = DW'(NUM_DIGITS - 1);

  logic [PW-1:0]                 prescaler;
  logic [DW-1:0]                 digit;
  logic [VW-1:0]                 shadow_value, eff_value;
  logic [NUM_DIGITS-1:0]         shadow_dp, eff_dp;
  logic [NUM_DIGITS-1:0][3:0]    nib;
  logic                          frame_start;
  logic [6:0]                    seg_nx;
  logic                          dp_nx;
  logic [NUM_DIGITS-1:0]         an_nx;
  logic                          unused_value_hi;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;  4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;  4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;  4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
    endcase
  endfunction

  // At frame start the live inputs bypass the shadow so digit 0 decodes the fresh snapshot.
  assign frame_start     = (prescaler == '0) && (digit == '0);
  assign eff_value       = frame_start ? value[VW-1:0] : shadow_value;
  assign eff_dp          = frame_start ? dp_mask : shadow_dp;
  assign nib             = eff_value;
  assign unused_value_hi = ^value;

`ifdef SEVEN_SEG_LZ_SUPPRESS_EN
  logic [NUM_DIGITS-1:0] lz;
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_lz
    assign lz[i] = ~|eff_value[VW-1:4*i];
  end
`endif

  always_comb begin
    seg_nx = hex7(nib[digit]);
`ifdef SEVEN_SEG_LZ_SUPPRESS_EN
    if (digit != '0 && lz[digit]) seg_nx = 7'h7F;
`endif
    dp_nx = ~eff_dp[digit];
    an_nx = (prescaler < BLANK_END) ? '1 : ~(NUM_DIGITS'(1) << digit);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prescaler    <= '0;
      digit        <= '0;
      shadow_value <= '0;
      shadow_dp    <= '0;
      seg_n        <= 7'h7F;
      dp_n         <= 1'b1;
      an_n         <= '1;
    end else begin
      if (prescaler == PRE_LAST) begin
        prescaler <= '0;
        digit     <= (digit == DIG_LAST) ? '0 : digit + 1'b1;
      end else begin
        prescaler <= prescaler + 1'b1;
      end
      shadow_value <= eff_value;
      shadow_dp    <= eff_dp;
      seg_n        <= seg_nx;
      dp_n         <= dp_nx;
      an_n         <= an_nx;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Scoreboard bench: stimulus pushes expected outputs derived from the time index; monitor pops and compares.
module tb_seven_seg_scan_driver;
  localparam int ND = 4, RD = 4, BL = 1;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] value;
  logic [3:0]  dp_mask;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [3:0]  an_n;

  seven_seg_scan_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYCLES(BL)) dut (
    .clk(clk), .reset_n(reset_n), .value(value), .dp_mask(dp_mask),
    .seg_n(seg_n), .dp_n(dp_n), .an_n(an_n));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
  } exp_t;

  exp_t        q[$];
  int          vectors = 0, errors = 0;
  int          m_s = 0;
  int          m_v = 0;
  logic [3:0]  m_dp = '0;
  logic [6:0]  hex [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  function automatic void cmp(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endfunction

  // Reference: cycle index after reset selects digit/phase; shadow is the word seen at each frame start.
  task automatic step_model(input logic [31:0] v, input logic [3:0] dp, input logic rst);
    exp_t e;
    int p, d, rest;
    if (!rst) begin
      e = '{seg: 7'h7F, dp: 1'b1, an: 4'hF};
      m_s = 0;
    end else begin
      p = m_s % RD;
      d = (m_s / RD) % ND;
      if (m_s % (RD * ND) == 0) begin
        m_v  = int'(v[15:0]);
        m_dp = dp;
      end
      rest  = m_v >> (4 * d);
      e.seg = hex[rest & 15];
`ifdef SEVEN_SEG_LZ_SUPPRESS_EN
      if (d > 0 && rest == 0) e.seg = 7'h7F;
`endif
      e.dp = ~m_dp[d];
      e.an = (p < BL) ? 4'hF : (4'hF ^ (4'b0001 << d));
      m_s++;
    end
    q.push_back(e);
  endtask

  task automatic cyc(input logic [31:0] v, input logic [3:0] dp, input logic rst);
    @(negedge clk);
    value   = v;
    dp_mask = dp;
    reset_n = rst;
    step_model(v, dp, rst);
    if (!rst) begin
      #1;
      cmp("async_rst_seg", int'(seg_n), 'h7F);
      cmp("async_rst_dp",  int'(dp_n), 1);
      cmp("async_rst_an",  int'(an_n), 'hF);
    end
  endtask

  task automatic frames(input logic [31:0] v, input logic [3:0] dp, input int n);
    for (int i = 0; i < n * RD * ND; i++) cyc(v, dp, 1'b1);
  endtask

  // Monitor: outputs are valid every cycle; compare against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      cmp("an_onehot", int'($countones(~an_n) <= 1), 1);
      if (q.size() > 0) begin
        e = q.pop_front();
        cmp("seg_n", int'(seg_n), int'(e.seg));
        cmp("dp_n",  int'(dp_n),  int'(e.dp));
        cmp("an_n",  int'(an_n),  int'(e.an));
      end
    end
  end

  initial begin
    logic [31:0] rv;
    logic [3:0]  rdp;
    reset_n = 1'b0;
    value   = 32'h1234;
    dp_mask = 4'h0;
    for (int i = 0; i < 3; i++) cyc(32'h1234, 4'h0, 1'b0);
    frames(32'h1234, 4'h0, 2);
    frames(32'h0000ABCD, 4'b0100, 2);
    // mid-frame write must not tear the current frame
    for (int i = 0; i < RD * ND; i++) cyc((i < 8) ? 32'h1234 : 32'h5678, 4'h0, 1'b1);
    frames(32'h5678, 4'h3, 1);
    // reset during digit 3, then restart
    for (int i = 0; i < 13; i++) cyc(32'hCAFE, 4'h8, 1'b1);
    for (int i = 0; i < 3; i++) cyc(32'hCAFE, 4'h8, 1'b0);
    frames(32'hCAFE, 4'h8, 1);
    frames(32'h00000050, 4'h0, 2);
    frames(32'h00000000, 4'h1, 1);
    // every nibble value, with junk above the used bits
    frames({16'hDEAD, 16'h3210}, 4'h0, 1);
    frames({16'hBEEF, 16'h7654}, 4'h5, 1);
    frames({16'h1357, 16'hBA98}, 4'hA, 1);
    frames({16'hFFFF, 16'hFEDC}, 4'hF, 1);
    rv  = $urandom;
    rdp = 4'($urandom);
    for (int i = 0; i < 30 * RD * ND; i++) begin
      if ($urandom_range(7) == 0) begin
        rv = $urandom;
        if ($urandom_range(3) == 0) rv[15:8] = 8'h00;
        rdp = 4'($urandom);
      end
      cyc(rv, rdp, ($urandom_range(199) == 0) ? 1'b0 : 1'b1);
    end
    @(posedge clk);
    #5;
    cmp("queue_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
